// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
// Imported by the byte packer and the loader top level.
package loader_pkg;

    typedef enum logic [1:0] {
        WAIT_HEADER,
        RECV_PAYLOAD,
        DONE,
        ERROR
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int HEADER_BYTES   = 4;

endpackage

// File: rtl/uart_program_loader_packer.sv
// Little-endian byte-to-word packer; word_ready/word are valid
// combinationally in the cycle the final byte is presented.
module byte_word_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [1:0]  byte_idx,
    output logic        word_ready,
    output logic [31:0] word
);

    localparam logic [1:0] LAST = 2'(BYTES_PER_WORD - 1);

    logic [23:0] shift;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            shift    <= '0;
            byte_idx <= '0;
        end else if (byte_valid) begin
            unique case (byte_idx)
                2'd0:    shift[7:0]   <= byte_in;
                2'd1:    shift[15:8]  <= byte_in;
                2'd2:    shift[23:16] <= byte_in;
                default: ;
            endcase
            byte_idx <= (byte_idx == LAST) ? 2'd0 : byte_idx + 2'd1;
        end
    end

    assign word_ready = byte_valid && (byte_idx == LAST);
    assign word       = {byte_in, shift};

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: parses a word count header and N little-endian words
// from the UART byte stream and writes them into instruction memory.
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 40_000_000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx_data_valid,
    input  logic [7:0]            rx_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_stall,
    output logic                  load_done,
    output logic                  load_error
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [32:0]   MAX_WORDS = 33'(1) << ADDR_WIDTH;
    localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]    HDR_LAST  = 2'(HEADER_BYTES - 1);

    loader_state_t state;
    logic [CW-1:0] n_words;
    logic [CW-1:0] word_cnt;
    logic [TW-1:0] tmo_cnt;

    logic        pk_valid;
    logic        pk_clear;
    logic [1:0]  byte_idx;
    logic        word_ready;
    logic [31:0] word;
    logic        timing;
    logic        expired;
    logic        hdr_done;
    logic        hdr_bad;

    assign pk_valid = rx_data_valid &&
                      (state == WAIT_HEADER || state == RECV_PAYLOAD);

    // An idle line before the first header byte never times out.
    assign timing  = (state == WAIT_HEADER && byte_idx != 2'd0) ||
                     state == RECV_PAYLOAD;
    assign expired = timing && !rx_data_valid && tmo_cnt == T_LAST;

    assign hdr_done = pk_valid && byte_idx == HDR_LAST;
    assign hdr_bad  = word == '0 || {1'b0, word} > MAX_WORDS;
    assign pk_clear = expired || (state == WAIT_HEADER && hdr_done);

    byte_word_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (pk_clear),
        .byte_valid (pk_valid),
        .byte_in    (rx_data),
        .byte_idx   (byte_idx),
        .word_ready (word_ready),
        .word       (word)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= WAIT_HEADER;
            n_words    <= '0;
            word_cnt   <= '0;
            tmo_cnt    <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_stall  <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (rx_data_valid || !timing)
                tmo_cnt <= '0;
            else if (!expired)
                tmo_cnt <= tmo_cnt + TW'(1);

            unique case (state)
                WAIT_HEADER: begin
                    if (expired) begin
                        state      <= ERROR;
                        load_error <= 1'b1;
                    end else if (hdr_done) begin
                        if (hdr_bad) begin
                            state      <= ERROR;
                            load_error <= 1'b1;
                        end else begin
                            n_words  <= word[CW-1:0];
                            word_cnt <= '0;
                            state    <= RECV_PAYLOAD;
                        end
                    end
                end
                RECV_PAYLOAD: begin
                    if (expired) begin
                        state      <= ERROR;
                        load_error <= 1'b1;
                    end else if (word_ready) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= word_cnt[ADDR_WIDTH-1:0];
                        mem_wdata <= word;
                        word_cnt  <= word_cnt + CW'(1);
                        if (word_cnt + CW'(1) == n_words) begin
                            state     <= DONE;
                            cpu_stall <= 1'b0;
                            load_done <= 1'b1;
                        end
                    end
                end
                DONE, ERROR: ;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
Downstream consumer of the UART receiver's byte stream. Parses a simple boot protocol: a 4-byte little-endian word count N, then N 32-bit words, each little-endian. Each assembled word is written into instruction memory at consecutive word addresses. The CPU is held in stall until the load completes.

Parameters:
ADDR_WIDTH, 10, word-address width of instruction memory; maximum load is 2**ADDR_WIDTH words.
TIMEOUT_CYCLES, 40_000_000, inter-byte timeout in clk cycles (1 s at 40 MHz); must be >= 2.

Ports:
clk  input  1  system clock, 40 MHz.
reset_n  input  1  synchronous, active-low reset.
rx_data_valid  input  1  one-cycle pulse; rx_data holds a received byte.
rx_data  input  8  received byte; sampled only when rx_data_valid=1.
mem_we  output  1  one-cycle instruction-memory write strobe.
mem_addr  output  ADDR_WIDTH  word address of the write (0-based).
mem_wdata  output  32  write data.
cpu_stall  output  1  holds CPU while loading; 1 until load completes.
load_done  output  1  sticky; load finished successfully.
load_error  output  1  sticky; protocol or timeout error.

Behaviour:
- Clock and reset: reset reset_n, synchronous, active-low; clock clk. All state updates on posedge clk.
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, cpu_stall=1, load_done=0, load_error=0. Internal state: state=WAIT_HEADER, byte index=0, word counter=0, timeout counter=0, shift register=0.
- Reset mid-operation discards all partial bytes and words. Words already written are not cleared. The next load restarts at address 0.
- States: WAIT_HEADER, RECV_PAYLOAD, DONE, ERROR.
- WAIT_HEADER:
  - Each valid byte shifts into the shift register, LSB byte first (byte k lands in bits [8k+7:8k]). Byte index increments 0..3.
  - On the 4th header byte, N = {rx_data, shift[23:0]}, a 32-bit unsigned value.
  - If N==0 or N > 2**ADDR_WIDTH (compare at 33 bits): go to ERROR.
  - Otherwise: latch N, clear the word counter and byte index, go to RECV_PAYLOAD.
- RECV_PAYLOAD:
  - Bytes assemble into a word the same way as the header.
  - On the 4th byte of a word, the next edge registers mem_we=1, mem_addr=word counter[ADDR_WIDTH-1:0], mem_wdata={rx_data, shift[23:0]}. Latency is 1 cycle after the edge that samples the byte.
  - mem_we is high for exactly one cycle per word and 0 otherwise. mem_addr and mem_wdata hold their values between writes.
  - The word counter increments with each write.
  - If it was the Nth word: go to DONE on the same edge that asserts mem_we.
- DONE: cpu_stall=0, load_done=1. All further bytes are ignored (no mem_we). Stays in DONE until reset.
- ERROR: load_error=1, cpu_stall stays 1, no writes. Stays in ERROR until reset.
- Timeout:
  - The counter runs only in WAIT_HEADER with byte index != 0, and in RECV_PAYLOAD. It clears on every rx_data_valid.
  - When TIMEOUT_CYCLES consecutive edges pass without a valid byte, go to ERROR. load_error is visible on that edge.
  - A valid byte arriving in the same cycle as expiry wins: the byte is accepted and there is no error.
  - WAIT_HEADER with byte index 0 waits indefinitely.
  - A partial word is never written.
- Simultaneous events: a byte arriving in the cycle mem_we is high is accepted normally; assembly is independent of the write strobe.
- Widths: word counter and N compare at ADDR_WIDTH+1 bits. Address wrap is impossible, since N <= 2**ADDR_WIDTH.

Decomposition:
- Package loader_pkg: state enum loader_state_t {WAIT_HEADER, RECV_PAYLOAD, DONE, ERROR}; constants BYTES_PER_WORD=4 and HEADER_BYTES=4.
- Sub-module byte_word_packer: byte shift register, 2-bit byte index, and word_ready pulse with 32-bit word output, plus a clear input. It is reused for both header and payload assembly.
- Top level holds the FSM, word counter, timeout counter and output registers.

Test Plan:
- Bytes 02 00 00 00 13 00 00 00 93 00 10 00 -> mem_we pulses twice: (addr 0, 0x00000013), then (addr 1, 0x00100093). load_done=1 and cpu_stall=0 from the cycle of the 2nd pulse. load_error=0.
- Header 00 00 00 00 -> load_error=1 one cycle after the 4th byte. No mem_we ever. cpu_stall stays 1.
- ADDR_WIDTH=4: header 11 00 00 00 (N=17) -> load_error. After reset, header 10 00 00 00 plus 64 bytes -> 16 writes, last at addr 15, load_done=1.
- TIMEOUT_CYCLES=1000: header 01 00 00 00, payload AA BB, then silence -> load_error=1 exactly 1000 edges after the BB sample, with no mem_we. A variant where a byte arrives on the expiry cycle -> no error.
- After a successful load (test 1), send DE AD BE EF -> no mem_we; load_done, cpu_stall and mem_addr unchanged.
- Reset asserted for 1 cycle after 5 payload bytes of an N=2 load -> all outputs at reset values. A fresh N=1 load with 78 56 34 12 -> write (addr 0, 0x12345678).
